// File: rtl/logic_capture_if.sv
// logic_capture_if: host register and sample-RAM signals of the logic-analyzer capture engine
interface logic_capture_if #(parameter int ADDR_W = 18);
    logic [31:0] status;
    logic [31:0] control;
    logic [31:0] config0;
    logic [31:0] config1;
    logic [7:0] datain;
    logic [7:0] dataout;
    logic we;
    logic en;
    logic [ADDR_W-1:0] address;
    modport master (
        input status, dataout, we, en, address,
        output control, config0, config1, datain
    );
    modport slave (
        output status, dataout, we, en, address,
        input control, config0, config1, datain
    );
endinterface

// File: rtl/logic_capture.sv
// logic_capture: 8-channel capture engine filling a circular sample RAM around a qualified edge trigger
module logic_capture #(
    parameter int ADDR_W = 18
) (
    input logic clk,
    input logic resetn,
    logic_capture_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREFILL = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        DONE    = 3'd4
    } state_t;
    localparam logic [31:0] MAXC = 32'((64'd1 << ADDR_W) - 64'd1);
    state_t state;
    logic [7:0] s1, s, p;
    logic start_d, done, triggered, we;
    logic [ADDR_W-1:0] ptr, cnt, pre_c, post_c;
    logic [ADDR_W:0] cnt_inc;
    logic [17:0] trig_addr;
    logic [31:0] pre_raw;
    logic [7:0] qual_ok;
    logic [2:0] ch;
    logic edge_hit, trig_hit, start_rise, pre_reached, post_reached;
    logic unused_bits;
    for (genvar k = 0; k < 8; k++) begin : g_q
        assign qual_ok[k] = !bus.config0[2*k+17] || (s[k] == bus.config0[2*k+16]);
    end
    assign ch = bus.config0[2:0];
    assign edge_hit = bus.config0[3] ? (!p[ch] && s[ch]) : (p[ch] && !s[ch]);
    assign trig_hit = edge_hit && (&qual_ok);
    assign start_rise = bus.control[0] && !start_d;
    // config is read live, so a PRE edit mid-capture changes the prefill and post lengths at once
    assign pre_raw = {14'd0, bus.config1[17:0]};
    assign pre_c = ADDR_W'((pre_raw > MAXC) ? MAXC : pre_raw);
    assign post_c = ADDR_W'(MAXC) - pre_c;
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign pre_reached = cnt_inc >= {1'b0, pre_c};
    assign post_reached = cnt_inc >= {1'b0, post_c};
    assign unused_bits = ^{bus.control[31:2], bus.config0[15:4], bus.config1[31:18]};
    assign bus.status = {trig_addr, 9'd0, triggered, done, state};
    assign bus.dataout = s;
    assign bus.we = we;
    assign bus.en = we;
    assign bus.address = ptr;
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= IDLE;
            s1 <= '0;
            s <= '0;
            p <= '0;
            start_d <= 1'b0;
            done <= 1'b0;
            triggered <= 1'b0;
            we <= 1'b0;
            ptr <= '0;
            cnt <= '0;
            trig_addr <= '0;
        end else begin
            s1 <= bus.datain;
            s <= s1;
            p <= s;
            start_d <= bus.control[0];
            if (bus.control[1]) begin
                state <= IDLE;
                we <= 1'b0;
                done <= 1'b0;
                triggered <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: if (start_rise) begin
                        ptr <= '0;
                        cnt <= '0;
                        done <= 1'b0;
                        triggered <= 1'b0;
                        we <= 1'b1;
                        state <= (pre_c == '0) ? ARMED : PREFILL;
                    end
                    PREFILL: begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt + 1'b1;
                        if (pre_reached) state <= ARMED;
                    end
                    // the trigger sample itself is written this cycle at ptr
                    ARMED: begin
                        ptr <= ptr + 1'b1;
                        if (trig_hit) begin
                            trig_addr <= 18'(ptr);
                            triggered <= 1'b1;
                            cnt <= '0;
                            state <= (post_c == '0) ? DONE : POST;
                            done <= (post_c == '0);
                            we <= (post_c != '0);
                        end
                    end
                    POST: begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt + 1'b1;
                        if (post_reached) begin
                            state <= DONE;
                            done <= 1'b1;
                            we <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        we <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_logic_capture.sv
// tb_logic_capture: scoreboarded RAM-write stream plus directed status checks for logic_capture
module tb_logic_capture;
    localparam int AW = 5;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;
    logic_capture_if #(.ADDR_W(AW)) bus ();
    logic_capture #(.ADDR_W(AW)) dut (.clk(clk), .resetn(resetn), .bus(bus));
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0] data;
        logic [2:0] st;
    } wr_t;
    wr_t q[$];
    wr_t e;
    int checks = 0;
    int errors = 0;
    bit track = 1'b0;
    logic [7:0] d;
    logic [31:0] rec_addr;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push(input int a, input logic [7:0] dat, input logic [2:0] st);
        q.push_back(wr_t'{addr: AW'(a), data: dat, st: st});
    endtask
    function automatic logic [7:0] pat2(input int i);
        return (i < 0) ? 8'h00 : {7'd0, ((i / 4) % 2) == 0};
    endfunction
    always @(negedge clk) begin
        if (resetn === 1'b0 && bus.we === 1'b1) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_addr", 32'(bus.address), 32'(e.addr));
                chk("wr_data", 32'(bus.dataout), 32'(e.data));
                chk("wr_state", 32'(bus.status[2:0]), 32'(e.st));
                chk("wr_en", 32'(bus.en), 32'd1);
            end else if (track) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected", bus.address, bus.dataout);
            end
        end
    end
    initial begin
        resetn = 1'b1;
        bus.control = '0;
        bus.config0 = '0;
        bus.config1 = '0;
        bus.datain = 8'hFF;
        step(3);
        chk("rst_status", bus.status, 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_en", 32'(bus.en), 32'd0);
        chk("rst_address", 32'(bus.address), 32'd0);
        chk("rst_dataout", 32'(bus.dataout), 32'd0);
        bus.datain = 8'h00;
        step(1);
        resetn = 1'b0;
        step(3);
        chk("rel_state", 32'(bus.status[2:0]), 32'd0);
        chk("rel_we", 32'(bus.we), 32'd0);
        // full capture: PRE=5, ch0 rising, prefill rise ignored, trigger at address 9
        bus.config0 = 32'h0000_0008;
        bus.config1 = 32'd5;
        track = 1'b1;
        for (int m = 1; m <= 36; m++)
            push((m - 1) % 32, pat2(m - 2), (m <= 5) ? 3'd1 : (m <= 10) ? 3'd2 : 3'd3);
        for (int i = 0; i <= 36; i++) begin
            bus.datain = pat2(i);
            if (i == 0) bus.control = 32'd1;
            step(1);
        end
        chk("t2_status", bus.status, (32'd9 << 14) | 32'h1C);
        chk("t2_we", 32'(bus.we), 32'd0);
        chk("t2_queue_left", q.size(), 32'd0);
        step(5);
        chk("held_start_state", 32'(bus.status[2:0]), 32'd4);
        chk("held_start_we", 32'(bus.we), 32'd0);
        // PRE=0 straight to ARMED, 100 cycles without trigger wrap the pointer
        bus.control = '0;
        bus.datain = 8'h00;
        bus.config1 = 32'd0;
        step(2);
        for (int m = 1; m <= 100; m++) push((m - 1) % 32, 8'h00, 3'd2);
        for (int i = 0; i < 100; i++) begin
            if (i == 0) bus.control = 32'd1;
            step(1);
            if (i == 31) chk("t5_addr31", 32'(bus.address), 32'd31);
            if (i == 32) chk("t5_wrap0", 32'(bus.address), 32'd0);
        end
        chk("t5_we", 32'(bus.we), 32'd1);
        chk("t5_trig", 32'(bus.status[4]), 32'd0);
        bus.control = 32'd2;
        step(1);
        chk("t5_abort_state", 32'(bus.status[2:0]), 32'd0);
        chk("t5_queue_left", q.size(), 32'd0);
        track = 1'b0;
        // qualifiers: ch1 must be 0, ch3 must be 1
        bus.config0 = 32'h00C8_0008;
        bus.control = '0;
        step(1);
        for (int i = 0; i < 30; i++) begin
            d = 8'h00;
            d[0] = ((i / 2) % 2) == 1;
            d[3] = i >= 10;
            d[1] = (i >= 10) && (i < 20);
            bus.datain = d;
            if (i == 0) bus.control = 32'd1;
            step(1);
            if (i == 0) chk("t3_pre0_armed", 32'(bus.status[2:0]), 32'd2);
            if (i == 0) chk("t3_pre0_addr", 32'(bus.address), 32'd0);
            if (i == 9 || i == 19) chk("t3_no_trig", 32'(bus.status[4:0]), 32'h02);
            if (i == 23) chk("t3_trig_cycle_addr", 32'(bus.address), 32'd23);
            if (i == 23) chk("t3_trig_cycle_st", 32'(bus.status[4:0]), 32'h02);
            if (i == 24) chk("t3_trig_st", 32'(bus.status[4:0]), 32'h13);
            if (i == 24) chk("t3_trig_addr", 32'(bus.status[31:14]), 32'd23);
        end
        // abort during POST, start ignored while aborting or held, then recapture
        bus.control = 32'd2;
        step(1);
        chk("t6_abort_st", 32'(bus.status[4:0]), 32'd0);
        chk("t6_abort_we", 32'(bus.we), 32'd0);
        bus.control = 32'd3;
        step(2);
        chk("t6_start_in_abort", 32'(bus.status[2:0]), 32'd0);
        bus.control = 32'd1;
        step(2);
        chk("t6_no_edge", 32'(bus.status[2:0]), 32'd0);
        bus.control = 32'd0;
        step(1);
        bus.control = 32'd1;
        step(1);
        chk("t6_rearm_state", 32'(bus.status[2:0]), 32'd2);
        chk("t6_rearm_addr", 32'(bus.address), 32'd0);
        chk("t6_rearm_we", 32'(bus.we), 32'd1);
        step(1);
        chk("t6_rearm_addr1", 32'(bus.address), 32'd1);
        // falling edge on channel 7, PRE=3
        bus.control = 32'd2;
        step(1);
        bus.control = 32'd0;
        bus.config0 = 32'h0000_0007;
        bus.config1 = 32'd3;
        bus.datain = 8'h00;
        step(2);
        rec_addr = '0;
        for (int i = 0; i <= 40; i++) begin
            d = 8'h00;
            d[0] = (i % 2) == 1;
            d[7] = (i == 0) || ((i >= 5) && (i < 10));
            bus.datain = d;
            if (i == 0) bus.control = 32'd1;
            step(1);
            if (i == 10) chk("t4_no_trig", 32'(bus.status[4:0]), 32'h02);
            if (i == 11) begin
                chk("t4_trig_cycle_addr", 32'(bus.address), 32'd11);
                rec_addr = 32'(bus.address);
            end
            if (i == 12) chk("t4_trig_st", 32'(bus.status[4:0]), 32'h13);
            if (i == 12) chk("t4_trig_addr", 32'(bus.status[31:14]), 32'd11);
            if (i == 12) chk("t4_trig_vs_ram", 32'(bus.status[31:14]), rec_addr);
            if (i == 40) chk("t4_done_st", 32'(bus.status[4:0]), 32'h1C);
            if (i == 40) chk("t4_done_we", 32'(bus.we), 32'd0);
        end
        // asynchronous reset mid-capture
        bus.control = 32'd0;
        step(1);
        bus.control = 32'd1;
        step(3);
        chk("t7_prefill", 32'(bus.status[2:0]), 32'd1);
        #2 resetn = 1'b1;
        #1;
        chk("t7_async_status", bus.status, 32'd0);
        chk("t7_async_we", 32'(bus.we), 32'd0);
        chk("t7_async_addr", 32'(bus.address), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
